// File: rtl/lspc2_timing_pkg.sv
// Default LSPC2 raster timing constants and the shared 9-bit counter type.
package lspc2_timing_pkg;

   typedef logic [8:0] cnt_t;

   localparam cnt_t DEF_H_TOTAL   = 9'd384;
   localparam cnt_t DEF_HSYNC_END = 9'd32;
   localparam cnt_t DEF_HBL_START = 9'd360;
   localparam cnt_t DEF_HBL_END   = 9'd40;

   localparam cnt_t DEF_V_FIRST   = 9'h0F8;
   localparam cnt_t DEF_V_LAST    = 9'h1FF;
   localparam cnt_t DEF_VSYNC_END = 9'h100;
   localparam cnt_t DEF_VBL_START = 9'h1F0;
   localparam cnt_t DEF_VBL_END   = 9'h110;

endpackage

// File: rtl/lspc2_wrap_cnt.sv
// 9-bit enabled counter that reloads load_val after reaching term_val.
// cnt_nxt exposes the value the counter takes on the coming edge.
module lspc2_wrap_cnt
   import lspc2_timing_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  cnt_t load_val,
   input  cnt_t term_val,
   output cnt_t cnt,
   output cnt_t cnt_nxt,
   output logic wrap
);

   assign wrap = (cnt == term_val);

   always_comb begin
      cnt_nxt = cnt;
      if (en)
         cnt_nxt = wrap ? load_val : cnt + 9'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= load_val;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/lspc2_hv_timing.sv
// LSPC2 raster timing: pixel/line counters, sync and blank strobes, and
// line/frame/vblank event pulses, all advanced by the 6 MHz pixel enable.
module lspc2_hv_timing
   import lspc2_timing_pkg::*;
#(
   parameter cnt_t H_TOTAL   = DEF_H_TOTAL,
   parameter cnt_t HSYNC_END = DEF_HSYNC_END,
   parameter cnt_t HBL_START = DEF_HBL_START,
   parameter cnt_t HBL_END   = DEF_HBL_END,
   parameter cnt_t V_FIRST   = DEF_V_FIRST,
   parameter cnt_t V_LAST    = DEF_V_LAST,
   parameter cnt_t VSYNC_END = DEF_VSYNC_END,
   parameter cnt_t VBL_START = DEF_VBL_START,
   parameter cnt_t VBL_END   = DEF_VBL_END
)(
   input  logic       CLK_24M,
   input  logic       RESETP,
   input  logic       PIXEL_CE,
   output logic [8:0] PIXELC,
   output logic [8:0] RASTERC,
   output logic       nHSYNC,
   output logic       nVSYNC,
   output logic       nBNK,
   output logic       LINE_START,
   output logic       FRAME_START,
   output logic       VBL_IRQ
);

   cnt_t pix_nxt;
   cnt_t ras_nxt;
   logic h_wrap;
   logic v_wrap;
   logic v_en;
   logic line_evt_p0;
   logic frame_evt_p0;
   logic vbl_evt_p0;

   function automatic logic hsync_n(input cnt_t pix);
      return !(pix < HSYNC_END);
   endfunction

   function automatic logic vsync_n(input cnt_t ras);
      return !((ras >= V_FIRST) && (ras < VSYNC_END));
   endfunction

   function automatic logic blank_n(input cnt_t pix, input cnt_t ras);
      logic hbl;
      logic vbl;
      hbl = (pix >= HBL_START) || (pix < HBL_END);
      vbl = (ras >= VBL_START) || (ras < VBL_END);
      return !(hbl || vbl);
   endfunction

   lspc2_wrap_cnt u_hcnt (
      .clk      (CLK_24M),
      .rst_n    (RESETP),
      .en       (PIXEL_CE),
      .load_val (9'd0),
      .term_val (H_TOTAL - 9'd1),
      .cnt      (PIXELC),
      .cnt_nxt  (pix_nxt),
      .wrap     (h_wrap)
   );

   assign v_en = h_wrap & PIXEL_CE;

   lspc2_wrap_cnt u_vcnt (
      .clk      (CLK_24M),
      .rst_n    (RESETP),
      .en       (v_en),
      .load_val (V_FIRST),
      .term_val (V_LAST),
      .cnt      (RASTERC),
      .cnt_nxt  (ras_nxt),
      .wrap     (v_wrap)
   );

   // Stage p0: strobes follow the counters on the same edge; events captured
   // Stage p1: event pulses, recomputed every cycle so they last one clock
   always_ff @(posedge CLK_24M or negedge RESETP) begin
      if (!RESETP) begin
         nHSYNC       <= 1'b0;
         nVSYNC       <= 1'b0;
         nBNK         <= 1'b0;
         line_evt_p0  <= 1'b0;
         frame_evt_p0 <= 1'b0;
         vbl_evt_p0   <= 1'b0;
         LINE_START   <= 1'b0;
         FRAME_START  <= 1'b0;
         VBL_IRQ      <= 1'b0;
      end else begin
         nHSYNC       <= hsync_n(pix_nxt);
         nVSYNC       <= vsync_n(ras_nxt);
         nBNK         <= blank_n(pix_nxt, ras_nxt);
         line_evt_p0  <= v_en;
         frame_evt_p0 <= v_en & v_wrap;
         vbl_evt_p0   <= v_en & (ras_nxt == VBL_START);
         LINE_START   <= line_evt_p0;
         FRAME_START  <= frame_evt_p0;
         VBL_IRQ      <= vbl_evt_p0;
      end
   end

endmodule

// File: tb/tb_lspc2_hv_timing.sv
// Directed bench for lspc2_hv_timing with a short line length so a full
// frame fits in a short run; vertical timing keeps its default values.
module tb_lspc2_hv_timing;

   localparam logic [8:0] HT      = 9'd64;
   localparam logic [8:0] HS_END  = 9'd8;
   localparam logic [8:0] HBL_S   = 9'd56;
   localparam logic [8:0] HBL_E   = 9'd10;
   localparam logic [8:0] V_FIRST = 9'h0F8;
   localparam logic [8:0] V_LAST  = 9'h1FF;
   localparam logic [8:0] VS_END  = 9'h100;
   localparam logic [8:0] VBL_S   = 9'h1F0;
   localparam logic [8:0] VBL_E   = 9'h110;

   typedef struct packed {
      logic [8:0] pix;
      logic [8:0] ras;
      logic       nh, nv, nb, ls, fs, vi;
   } exp_t;

   logic       clk;
   logic       RESETP;
   logic       PIXEL_CE;
   logic [8:0] PIXELC, RASTERC;
   logic       nHSYNC, nVSYNC, nBNK, LINE_START, FRAME_START, VBL_IRQ;

   int   total;
   int   bad;
   exp_t sb[$];
   logic [8:0] m_pix, m_ras;
   logic       m_line, m_frame, m_vbl;

   lspc2_hv_timing #(
      .H_TOTAL(HT), .HSYNC_END(HS_END), .HBL_START(HBL_S), .HBL_END(HBL_E),
      .V_FIRST(V_FIRST), .V_LAST(V_LAST), .VSYNC_END(VS_END),
      .VBL_START(VBL_S), .VBL_END(VBL_E)
   ) dut (
      .CLK_24M(clk), .RESETP(RESETP), .PIXEL_CE(PIXEL_CE),
      .PIXELC(PIXELC), .RASTERC(RASTERC), .nHSYNC(nHSYNC), .nVSYNC(nVSYNC),
      .nBNK(nBNK), .LINE_START(LINE_START), .FRAME_START(FRAME_START),
      .VBL_IRQ(VBL_IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pix"}, PIXELC, 9'd0);
      chk({tag, "_ras"}, RASTERC, V_FIRST);
      chk({tag, "_nh"}, nHSYNC, 0);
      chk({tag, "_nv"}, nVSYNC, 0);
      chk({tag, "_nb"}, nBNK, 0);
      chk({tag, "_ls"}, LINE_START, 0);
      chk({tag, "_fs"}, FRAME_START, 0);
      chk({tag, "_vi"}, VBL_IRQ, 0);
   endtask

   // One clock: drive enable, predict outputs after the edge, compare at +1.
   task automatic step(input logic ce);
      exp_t e;
      PIXEL_CE = ce;
      if (!RESETP) begin
         m_pix = 9'd0; m_ras = V_FIRST;
         m_line = 1'b0; m_frame = 1'b0; m_vbl = 1'b0;
         e = '0;
         e.ras = V_FIRST;
      end else begin
         e.ls = m_line; e.fs = m_frame; e.vi = m_vbl;
         m_line  = ce && (m_pix == HT - 9'd1);
         m_frame = m_line && (m_ras == V_LAST);
         m_vbl   = m_line && (m_ras == VBL_S - 9'd1);
         if (ce) begin
            if (m_pix == HT - 9'd1) begin
               m_pix = 9'd0;
               m_ras = (m_ras == V_LAST) ? V_FIRST : m_ras + 9'd1;
            end else begin
               m_pix = m_pix + 9'd1;
            end
         end
         e.pix = m_pix;
         e.ras = m_ras;
         e.nh  = !(m_pix < HS_END);
         e.nv  = !((m_ras >= V_FIRST) && (m_ras < VS_END));
         e.nb  = !((m_pix >= HBL_S) || (m_pix < HBL_E) ||
                   (m_ras >= VBL_S) || (m_ras < VBL_E));
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pixelc", PIXELC, e.pix);
      chk("rasterc", RASTERC, e.ras);
      chk("nhsync", nHSYNC, e.nh);
      chk("nvsync", nVSYNC, e.nv);
      chk("nbnk", nBNK, e.nb);
      chk("line_start", LINE_START, e.ls);
      chk("frame_start", FRAME_START, e.fs);
      chk("vbl_irq", VBL_IRQ, e.vi);
   endtask

   initial begin
      int vis, virq, fstarts, ls_cnt;
      logic [8:0] virq_ras, vs_rise_ras, vs_fall_ras;
      logic prev_nv;
      total = 0; bad = 0;
      RESETP = 1'b0; PIXEL_CE = 1'b0;
      m_pix = 9'd0; m_ras = V_FIRST; m_line = 0; m_frame = 0; m_vbl = 0;

      // Reset hold, then release with an enable every 4th cycle for one line
      repeat (3) step(1'b0);
      chk_reset("rst_hold");
      RESETP = 1'b1;
      for (int i = 1; i <= HT; i++) begin
         step(1'b1);
         if (i == 1) chk("first_en", PIXELC, 9'd1);
         if (i == HS_END - 1) chk("hsync_low", nHSYNC, 0);
         if (i == HS_END) chk("hsync_high", nHSYNC, 1);
         if (i == HT - 1) chk("pre_wrap", PIXELC, HT - 9'd1);
         if (i == HT) begin
            chk("wrap_pix", PIXELC, 9'd0);
            chk("wrap_ras", RASTERC, 9'h0F9);
            chk("wrap_ls_wait", LINE_START, 0);
         end
         step(1'b0);
         if (i == HT) begin
            chk("line_ls_on", LINE_START, 1);
            chk("line_fs_off", FRAME_START, 0);
         end
         step(1'b0);
         if (i == HT) chk("line_ls_off", LINE_START, 0);
         step(1'b0);
      end

      // Full frame from reset with a continuous enable
      RESETP = 1'b0;
      step(1'b0);
      RESETP = 1'b1;
      vis = 0; virq = 0; fstarts = 0;
      virq_ras = 9'd0; vs_rise_ras = 9'd0; vs_fall_ras = 9'd0;
      prev_nv = nVSYNC;
      for (int i = 1; i <= 264 * HT; i++) begin
         if (i == 264 * HT) begin
            chk("frame_last_ras", RASTERC, V_LAST);
            chk("frame_last_pix", PIXELC, HT - 9'd1);
         end
         step(1'b1);
         if (nBNK) vis++;
         if (VBL_IRQ) begin virq++; virq_ras = RASTERC; end
         if (FRAME_START) fstarts++;
         if (nVSYNC && !prev_nv) vs_rise_ras = RASTERC;
         if (!nVSYNC && prev_nv) vs_fall_ras = RASTERC;
         prev_nv = nVSYNC;
      end
      chk("frame_wrap_ras", RASTERC, V_FIRST);
      step(1'b0);
      chk("frame_fs_on", FRAME_START, 1);
      chk("frame_ls_on", LINE_START, 1);
      step(1'b0);
      chk("frame_fs_off", FRAME_START, 0);
      chk("frame_fs_early", fstarts[8:0], 9'd0);
      chk("visible_cnt_lo", vis[8:0], 9'(46 * 224));
      chk("visible_cnt_hi", 9'(vis >> 9), 9'((46 * 224) >> 9));
      chk("vbl_irq_cnt", virq[8:0], 9'd1);
      chk("vbl_irq_line", virq_ras, VBL_S);
      chk("vsync_rise_line", vs_rise_ras, VS_END);
      chk("vsync_fall_line", vs_fall_ras, V_FIRST);

      // Back-to-back enables ending on the wrap, then a long gap
      for (int i = 0; i < HT - 10; i++) step(1'b1);
      chk("gap_start", PIXELC, HT - 9'd10);
      for (int i = 0; i < 10; i++) step(1'b1);
      chk("gap_adv", PIXELC, 9'd0);
      step(1'b0);
      chk("gap_ls_on", LINE_START, 1);
      step(1'b0);
      chk("gap_ls_off", LINE_START, 0);
      for (int i = 0; i < 48; i++) step(1'b0);
      chk("gap_hold", PIXELC, 9'd0);
      chk("gap_hold_ras", RASTERC, 9'h0F9);

      // Asynchronous reset mid-line, between clock edges
      for (int i = 0; i < 87 * HT + 40; i++) step(1'b1);
      chk("mid_pix", PIXELC, 9'd40);
      chk("mid_ras", RASTERC, 9'h150);
      RESETP = 1'b0;
      #1;
      chk_reset("async_rst");
      step(1'b0);
      step(1'b0);
      RESETP = 1'b1;
      ls_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         if (LINE_START) ls_cnt++;
         step(1'b0);
         if (LINE_START) ls_cnt++;
      end
      chk("rel_no_ls", ls_cnt[8:0], 9'd0);
      chk("rel_pix", PIXELC, 9'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
